inst_fetch_unit: RTL

// Front end of the RV64 pipeline: issues in-order word fetches to instruction memory,

---
 rtl/inst_fetch_unit.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/inst_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : inst_fetch_unit
//  Description : RV64 instruction fetch front end. Issues in-order word
//                fetches to instruction memory, queues returned words with
//                their PCs, and presents one instruction per cycle to decode.
//                Honours the decode hold (stall) and branch redirects
//                (flush queue, discard in-flight responses, restart fetch).
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    RESET_PC    first fetch address after reset
//    FIFO_DEPTH  queue entries and max requests outstanding (power of 2, >=2)
//    NOP_INST    instruction driven when no valid instruction is available
//  Ports
//    CLK          in   1   clock, rising edge
//    reset        in   1   asynchronous, active-low reset
//    imem_req     out  1   fetch request valid
//    imem_addr    out  64  fetch address
//    imem_ready   in   1   memory accepts request (req & ready = accept)
//    imem_rvalid  in   1   read data valid, responses in request order
//    imem_rdata   in   32  instruction word
//    stall        in   1   decode hold: keep outputs, do not pop queue
//    redirect     in   1   branch taken / flush, single-cycle pulse
//    redirect_pc  in   64  new fetch address, valid with redirect
//    inst         out  32  instruction to decode
//    PC_o         out  64  PC of inst
//    inst_valid   out  1   inst is a real fetched instruction
// ============================================================================
module inst_fetch_unit #(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input  logic        CLK,
    input  logic        reset,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    output logic [31:0] inst,
    output logic [63:0] PC_o,
    output logic        inst_valid
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // One extra bit so outstanding + count can never wrap in the compare.
    localparam logic [CNT_W:0] DEPTH_EXT = (CNT_W + 1)'(FIFO_DEPTH);

    localparam logic [0:0] ST_BOOT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [0:0]       state_q,       state_d;
    logic [63:0]      fetch_pc_q,    fetch_pc_d;
    logic [63:0]      resp_pc_q,     resp_pc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] discard_q,     discard_d;
    logic [CNT_W-1:0] count_q,       count_d;
    logic [PTR_W-1:0] head_q,        head_d;
    logic [PTR_W-1:0] tail_q,        tail_d;
    logic [31:0]      inst_q,        inst_d;
    logic [63:0]      pc_out_q,      pc_out_d;
    logic             inst_valid_q,  inst_valid_d;

    // Queue storage: {pc, word}. Contents are qualified by count, so no reset.
    logic [95:0]      mem_q [FIFO_DEPTH];

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    logic             run;
    logic [CNT_W:0]   credit_used;
    logic             accept;
    logic             resp_fire;
    logic             drop;
    logic             push;
    logic             pop;
    logic [95:0]      head_entry;

    always_comb begin
        run         = (state_q == ST_RUN);
        credit_used = {1'b0, outstanding_q} + {1'b0, count_q};
        // Credit rule: every outstanding request has a reserved queue slot.
        imem_req    = run && !redirect && (credit_used < DEPTH_EXT);
        imem_addr   = fetch_pc_q;
        accept      = imem_req && imem_ready;
        // A response with nothing outstanding is a memory protocol error.
        resp_fire   = imem_rvalid && (outstanding_q != '0);
        drop        = (discard_q != '0);
        // Redirect wins over push: that cycle's response is dropped.
        push        = resp_fire && !drop && !redirect;
        pop         = !redirect && !stall && (count_q != '0);
        head_entry  = mem_q[head_q];
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = ST_RUN;
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        count_d       = count_q;
        head_d        = head_q;
        tail_d        = tail_q;
        inst_d        = inst_q;
        pc_out_d      = pc_out_q;
        inst_valid_d  = inst_valid_q;

        // Outstanding requests: accept adds, any retired response removes.
        case ({accept, resp_fire})
            2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
            2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
            default: outstanding_d = outstanding_q;
        endcase

        if (redirect) begin
            fetch_pc_d   = redirect_pc;
            resp_pc_d    = redirect_pc;
            // Everything still in flight after this cycle belongs to the old
            // path; in-order memory guarantees these arrive before new data.
            discard_d    = outstanding_q - CNT_W'(resp_fire);
            count_d      = '0;
            head_d       = '0;
            tail_d       = '0;
            inst_d       = NOP_INST;
            inst_valid_d = 1'b0;
        end else begin
            if (accept) begin
                fetch_pc_d = fetch_pc_q + 64'd4;
            end

            if (resp_fire && drop) begin
                discard_d = discard_q - CNT_W'(1);
            end

            if (push) begin
                resp_pc_d = resp_pc_q + 64'd4;
                tail_d    = tail_q + PTR_W'(1);
            end

            if (pop) begin
                head_d = head_q + PTR_W'(1);
            end

            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase

            // Output register: hold on stall, pop the prior head, or bubble.
            if (!stall) begin
                if (count_q != '0) begin
                    inst_d       = head_entry[31:0];
                    pc_out_d     = head_entry[95:32];
                    inst_valid_d = 1'b1;
                end else begin
                    inst_d       = NOP_INST;
                    inst_valid_d = 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_BOOT;
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            count_q       <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            inst_q        <= NOP_INST;
            pc_out_q      <= 64'h0;
            inst_valid_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            count_q       <= count_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            inst_q        <= inst_d;
            pc_out_q      <= pc_out_d;
            inst_valid_q  <= inst_valid_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[tail_q] <= {resp_pc_q, imem_rdata};
        end
    end

    assign inst       = inst_q;
    assign PC_o       = pc_out_q;
    assign inst_valid = inst_valid_q;

endmodule
`default_nettype wire
